dark_channel_win3x3: RTL
========================

# dark_channel_win3x3

Streaming 3×3 spatial minimum filter for the dark-channel stage of the haze-removal pipeline. It consumes the per-pixel RGB-minimum stream one 8-bit sample per accepted cycle, in raster order. It buffers two image lines and emits the minimum over each fully populated 3×3 window. Its output stream feeds the transmission-estimate stage.

## Interface
Parameters:
- IMG_WIDTH, 640, pixels per line; must be ≥ 3.
- PIX_W, 8, sample width in bits.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  sample present this cycle; there is no backpressure.
- in_sof  in  1  qualified by in_valid; marks pixel (0,0) of a frame.
- in_data  in  PIX_W  per-pixel RGB-minimum sample.
- out_valid  out  1  window result present.
- out_data  out  PIX_W  minimum of the 3×3 window.
- out_sof  out  1  first result of the frame (window centred at (1,1)).
- out_eol  out  1  last result of the line (window centred at column IMG_WIDTH-2).

## Operation
- Counters:
  - col counts 0..IMG_WIDTH-1 and wraps to 0 on each accepted sample.
  - row_cnt increments when col wraps and saturates at 2.
- Accepted sample with in_sof=1: the sample is treated as col=0, row_cnt=0, whatever the prior counter state. This also covers an abort mid-frame; no partial-frame output follows the abort.
- Line buffers: two memories of IMG_WIDTH×PIX_W, lb1 (row y-1) and lb2 (row y-2).
  - On accept, read lb1[col] and lb2[col].
  - Write lb2[col] ← old lb1[col] and lb1[col] ← in_data in the same cycle (read-before-write).
- Vertical stage: v = min(in_data, lb1[col], lb2[col]).
- Horizontal stage: a two-entry shift register h1/h2 of previous v values, advanced only on accept. w = min(v, h1, h2).
- Result valid condition: the accepted sample has col ≥ 2 and row_cnt = 2, i.e. the window is fully inside the image. This gives exactly (IMG_WIDTH-2)×(H-2) results per frame of height H. No frame-height parameter is needed.
- out_sof is asserted when a result is produced with col=2 and this is the first result since the last in_sof.
- out_eol is asserted when a result is produced with col=IMG_WIDTH-1.
- Comparisons are unsigned. Ties need no arbitration because the value is identical.
- in_valid=0: all state and outputs hold, except that out_valid, out_sof and out_eol deassert.
- Line-buffer contents are not reset. Stale data is never used because of the row_cnt gating.

## Timing
- Reset values: out_valid=0, out_data=0, out_sof=0, out_eol=0, col=0, row_cnt=0, h1=h2=all-ones.
- Base latency: 1 cycle. The result for the window ending at sample (x,y) is registered on the edge that accepts (x,y) and is visible the following cycle.
- Throughput: one sample per cycle sustained. Arbitrary in_valid gaps are allowed, including within a line.
- Reset asserted mid-frame clears everything immediately. The next frame must begin with in_sof.
- in_sof on the same cycle as a col wrap: in_sof wins.

## Configuration
- DARK_WIN_PIPE_EN defined:
  - A register is inserted between the vertical min and the horizontal stage.
  - Latency becomes 2 accepted-cycle-independent clock cycles. The pipe register advances every cycle; its valid bit is carried alongside.
  - out_sof and out_eol are delayed identically.
- DARK_WIN_PIPE_EN undefined: the single-cycle path described above.

## Structure
- Shared package haze_pkg:
  - PIX_W default.
  - PIX_MAX (all-ones) constant, used for shift-register reset.
  - Pixel typedef pix_t.
- One sub-module, min3_u8: combinational unsigned minimum of three pix_t values, instantiated twice (vertical and horizontal stages).

## Test plan
All scenarios use IMG_WIDTH=4 unless stated otherwise.
- Reset check: hold reset_n=0, drive traffic → all outputs 0. Release, send one 4×3 frame of values 10..21 in raster order → exactly 2 results, 10 then 11. out_sof on the first, out_eol on the second.
- Single dark pixel: 4×4 frame of 200, with 5 at (1,1) → 4 results, all 5. Move the dark pixel to (3,3) → results 200, 200, 200, 5.
- Gapped input: same frame as the dark-pixel case with in_valid deasserted for 3 cycles after every sample → identical result sequence. out_valid pulses only 1 cycle (2 with the macro) after the accept.
- Mid-frame abort: in_sof reasserted at sample 6 of a frame → no output until the new frame's row 2 col 2. Results then match a clean frame.
- Extremes: all 0xFF frame → all 0xFF. A frame of 0x00 except a 0xFF row → all results 0x00.
- Macro build: repeat the first scenario with DARK_WIN_PIPE_EN defined → same values, each exactly one cycle later.

Source files
------------

// File: rtl/haze_pkg.sv
// -----------------------------------------------------------------------------
// haze_pkg
// Shared definitions for the haze-removal pipeline blocks.
//   PIX_W   : default sample width in bits
//   PIX_MAX : all-ones pixel, used as the neutral element for running minima
//   pix_t   : pixel sample type
// -----------------------------------------------------------------------------
package haze_pkg;

    localparam int PIX_W = 8;

    typedef logic [PIX_W-1:0] pix_t;

    localparam pix_t PIX_MAX = '1;

endpackage : haze_pkg

// File: rtl/min3_u8.sv
// -----------------------------------------------------------------------------
// min3_u8
// Combinational unsigned minimum of three pixel samples.
// Ports:
//   a_i, b_i, c_i : candidate samples
//   min_o         : smallest of the three (ties are value-identical)
// -----------------------------------------------------------------------------
module min3_u8
    import haze_pkg::*;
(
    input  pix_t a_i,
    input  pix_t b_i,
    input  pix_t c_i,
    output pix_t min_o
);

    pix_t ab;

    assign ab    = (a_i < b_i) ? a_i : b_i;
    assign min_o = (ab < c_i) ? ab : c_i;

endmodule : min3_u8

// File: rtl/dark_channel_win3x3.sv
// -----------------------------------------------------------------------------
// dark_channel_win3x3
// Streaming 3x3 spatial minimum filter (dark-channel stage). Consumes one
// RGB-minimum sample per accepted cycle in raster order, keeps two previous
// lines in line buffers and emits the minimum of every fully populated window.
//
// Ports:
//   clock     : single clock, rising edge
//   reset_n   : asynchronous active-low reset
//   in_valid  : sample present (no backpressure)
//   in_sof    : with in_valid, marks pixel (0,0) of a frame
//   in_data   : per-pixel RGB-minimum sample
//   out_valid : window result present
//   out_data  : minimum of the 3x3 window
//   out_sof   : first result of the frame (window centred at (1,1))
//   out_eol   : last result of the line (window centred at IMG_WIDTH-2)
//
// Build option: define DARK_WIN_PIPE_EN to insert a free-running register
// between the vertical and horizontal minimum stages (latency 1 -> 2 cycles).
// PIX_W must equal haze_pkg::PIX_W; internal datapaths use pix_t.
// -----------------------------------------------------------------------------
module dark_channel_win3x3 #(
    parameter int IMG_WIDTH = 640,
    parameter int PIX_W     = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_data,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_data,
    output logic             out_sof,
    output logic             out_eol
);

    import haze_pkg::*;

    localparam int              CW       = $clog2(IMG_WIDTH);
    localparam logic [CW-1:0]   LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0]   FIRST_RES_COL = CW'(2);

    // ---------------- position tracking ----------------
    logic [CW-1:0] col_q, col_d, eff_col;
    logic [1:0]    row_q, row_d, eff_row;
    logic          col_wrap;
    logic          first_pend_q;
    logic          res_hit, sof_hit, eol_hit;

    // An accepted in_sof restarts the frame regardless of counter state.
    assign eff_col  = in_sof ? '0   : col_q;
    assign eff_row  = in_sof ? 2'd0 : row_q;
    assign col_wrap = (eff_col == LAST_COL);
    assign col_d    = col_wrap ? '0 : eff_col + CW'(1);
    assign row_d    = (col_wrap && (eff_row != 2'd2)) ? eff_row + 2'd1 : eff_row;

    // Window is entirely inside the image only from row 2, column 2 onward.
    assign res_hit = in_valid && (eff_row == 2'd2) && (eff_col >= FIRST_RES_COL);
    assign sof_hit = res_hit && (eff_col == FIRST_RES_COL) && first_pend_q;
    assign eol_hit = res_hit && col_wrap;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            col_q        <= '0;
            row_q        <= 2'd0;
            first_pend_q <= 1'b0;
        end else if (in_valid) begin
            col_q <= col_d;
            row_q <= row_d;
            if (in_sof) begin
                first_pend_q <= 1'b1;
            end else if (res_hit) begin
                first_pend_q <= 1'b0;
            end
        end
    end

    // ---------------- line buffers ----------------
    // Not reset: row gating guarantees stale contents are never emitted.
    pix_t lb1_mem [IMG_WIDTH];
    pix_t lb2_mem [IMG_WIDTH];
    pix_t lb1_rd, lb2_rd;

    assign lb1_rd = lb1_mem[eff_col];
    assign lb2_rd = lb2_mem[eff_col];

    // Read-before-write: the old row y-1 value shifts down to the y-2 buffer.
    always_ff @(posedge clock) begin
        if (in_valid) begin
            lb2_mem[eff_col] <= lb1_rd;
            lb1_mem[eff_col] <= pix_t'(in_data);
        end
    end

    // ---------------- vertical stage ----------------
    pix_t v_min;

    min3_u8 u_vmin (
        .a_i   (pix_t'(in_data)),
        .b_i   (lb1_rd),
        .c_i   (lb2_rd),
        .min_o (v_min)
    );

    // ---------------- optional mid-pipe register ----------------
    pix_t h_in;
    logic h_acc, h_res, h_sof, h_eol;

`ifdef DARK_WIN_PIPE_EN
    pix_t v_q;
    logic vacc_q, vres_q, vsof_q, veol_q;

    // Advances every cycle; the accept bit travels with the data so the
    // horizontal stage only shifts on real samples.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v_q    <= PIX_MAX;
            vacc_q <= 1'b0;
            vres_q <= 1'b0;
            vsof_q <= 1'b0;
            veol_q <= 1'b0;
        end else begin
            v_q    <= v_min;
            vacc_q <= in_valid;
            vres_q <= res_hit;
            vsof_q <= sof_hit;
            veol_q <= eol_hit;
        end
    end

    assign h_in  = v_q;
    assign h_acc = vacc_q;
    assign h_res = vres_q;
    assign h_sof = vsof_q;
    assign h_eol = veol_q;
`else
    assign h_in  = v_min;
    assign h_acc = in_valid;
    assign h_res = res_hit;
    assign h_sof = sof_hit;
    assign h_eol = eol_hit;
`endif

    // ---------------- horizontal stage ----------------
    pix_t h1_q, h2_q, w_min;
    pix_t out_data_q;
    logic out_valid_q, out_sof_q, out_eol_q;

    min3_u8 u_hmin (
        .a_i   (h_in),
        .b_i   (h1_q),
        .c_i   (h2_q),
        .min_o (w_min)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h1_q        <= PIX_MAX;
            h2_q        <= PIX_MAX;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
        end else begin
            out_valid_q <= h_res;
            out_sof_q   <= h_sof;
            out_eol_q   <= h_eol;
            if (h_acc) begin
                h1_q <= h_in;
                h2_q <= h1_q;
            end
            // Data holds between results; only window results update it.
            if (h_res) begin
                out_data_q <= w_min;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = PIX_W'(out_data_q);
    assign out_sof   = out_sof_q;
    assign out_eol   = out_eol_q;

endmodule : dark_channel_win3x3
